// File: rtl/johnson_phase_ctrl.sv
// ---------------------------------------------------------------------------
// johnson_phase_ctrl
//
// Sequencer for a WIDTH-bit Johnson phase register (2*WIDTH states). A small
// FSM (IDLE/RUN/DONE) decides when the register advances: single step, fixed
// burst or continuous run, forward or reverse, with hold, stop, preset load
// and protection against illegal preset values. The register contents are
// decoded into a one-hot phase bus for downstream multi-phase timing logic.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset (highest priority)
//   start      launch a run (IDLE only)
//   mode       00 single, 01 burst, 10 continuous, 11 behaves as single
//   dir        0 forward (0,1,3,7..), 1 reverse (0,8,C,E..)
//   burst_len  step count for burst mode
//   hold       freeze while running
//   stop       abort the run
//   load       preset q from load_val (IDLE only, start has priority)
//   load_val   preset value
//   busy       high while in RUN
//   done       one-cycle pulse when a run ends
//   q          Johnson register
//   phase      one-hot phase index decoded from q
//   err        sticky flag: an illegal load_val was presented
// ---------------------------------------------------------------------------
module johnson_phase_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic               dir,
    input  logic [CNT_W-1:0]   burst_len,
    input  logic               hold,
    input  logic               stop,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   q,
    output logic [2*WIDTH-1:0] phase,
    output logic               err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [1:0] MODE_BURST = 2'b01;
    localparam logic [1:0] MODE_CONT  = 2'b10;
    localparam int         PW         = $clog2(WIDTH + 1);
    localparam int         KW         = $clog2(2 * WIDTH);

    state_t             r_state;
    logic [1:0]         r_mode;
    logic               r_dir;
    logic [CNT_W-1:0]   r_remaining;
    logic [WIDTH-1:0]   r_q;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic [WIDTH-1:0]   w_next_q;
    logic               w_load_ok;
    logic [PW-1:0]      w_pop;
    logic [KW-1:0]      w_k;

    // A Johnson code has at most one boundary between its run of ones and
    // its run of zeros; any value with more boundaries is unreachable.
    function automatic logic is_legal(input logic [WIDTH-1:0] v);
        int t;
        t = 0;
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (v[i] != v[i+1]) t++;
        end
        return (t <= 1);
    endfunction

    assign w_load_ok = is_legal(load_val);
    assign w_next_q  = r_dir ? {~r_q[0], r_q[WIDTH-1:1]}
                             : {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_mode      <= 2'b00;
            r_dir       <= 1'b0;
            r_remaining <= '0;
            r_q         <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode      <= mode;
                        r_dir       <= dir;
                        r_remaining <= (mode == MODE_BURST) ? burst_len : CNT_W'(1);
                        if (mode == MODE_BURST && burst_len == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                        end
                    end else if (load) begin
                        if (w_load_ok) begin
                            r_q <= load_val;
                        end else begin
                            r_q   <= '0;
                            r_err <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (!hold) begin
                        r_q <= w_next_q;
                        if (r_mode != MODE_CONT) begin
                            r_remaining <= r_remaining - CNT_W'(1);
                            if (r_remaining == CNT_W'(1)) begin
                                r_state <= S_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Phase index: ones count for the rising half of the sequence (q[0]=1
    // or q=0), 2*WIDTH minus ones count for the falling half. The modular
    // KW-bit subtraction yields 2*WIDTH-p directly.
    // NOTE: every combinational output gets a default before any
    // conditional update, so no latch can be inferred.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + PW'(r_q[i]);
        end
        if (r_q[0] || (r_q == '0)) begin
            w_k = KW'(w_pop);
        end else begin
            w_k = KW'(2 * WIDTH) - KW'(w_pop);
        end
        phase      = '0;
        phase[w_k] = 1'b1;
    end

    assign q    = r_q;
    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;

endmodule

// File: tb/tb_johnson_phase_ctrl.sv
// ---------------------------------------------------------------------------
// tb_johnson_phase_ctrl
//
// Directed bench for johnson_phase_ctrl (WIDTH=4, CNT_W=8). Inputs change
// 1 ns after the rising edge and outputs are sampled at the same point, so
// every observation reflects the state produced by the preceding edge.
// ---------------------------------------------------------------------------
module tb_johnson_phase_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] mode;
    logic       dir;
    logic [7:0] burst_len;
    logic       hold;
    logic       stop;
    logic       load;
    logic [3:0] load_val;
    logic       busy;
    logic       done;
    logic [3:0] q;
    logic [7:0] phase;
    logic       err;

    int total = 0;
    int bad   = 0;

    logic [3:0] fwd_seq [10];

    johnson_phase_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .dir       (dir),
        .burst_len (burst_len),
        .hold      (hold),
        .stop      (stop),
        .load      (load),
        .load_val  (load_val),
        .busy      (busy),
        .done      (done),
        .q         (q),
        .phase     (phase),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        fwd_seq[0] = 4'h1; fwd_seq[1] = 4'h3; fwd_seq[2] = 4'h7; fwd_seq[3] = 4'hF;
        fwd_seq[4] = 4'hE; fwd_seq[5] = 4'hC; fwd_seq[6] = 4'h8; fwd_seq[7] = 4'h0;
        fwd_seq[8] = 4'h1; fwd_seq[9] = 4'h3;

        reset = 1'b1; start = 1'b0; mode = 2'b00; dir = 1'b0; burst_len = 8'd0;
        hold = 1'b0; stop = 1'b0; load = 1'b0; load_val = 4'h0;
        step();
        step();
        reset = 1'b0;
        check("rst_q", 16'(q), 16'h0);
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_done", 16'(done), 16'h0);
        check("rst_err", 16'(err), 16'h0);
        check("rst_phase", 16'(phase), 16'h01);

        // Forward burst of 10.
        start = 1'b1; mode = 2'b01; dir = 1'b0; burst_len = 8'd10;
        step();
        start = 1'b0;
        check("burst_start_busy", 16'(busy), 16'h1);
        check("burst_start_q", 16'(q), 16'h0);
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("burst_q%0d", i), 16'(q), 16'(fwd_seq[i]));
            check($sformatf("burst_busy%0d", i), 16'(busy), (i < 9) ? 16'h1 : 16'h0);
            check($sformatf("burst_done%0d", i), 16'(done), (i == 9) ? 16'h1 : 16'h0);
        end
        step();
        check("burst_after_done", 16'(done), 16'h0);
        check("burst_after_q", 16'(q), 16'h3);
        check("burst_after_phase", 16'(phase), 16'h04);

        // Reverse single step from preset C.
        load = 1'b1; load_val = 4'hC;
        step();
        load = 1'b0;
        check("load_c_q", 16'(q), 16'hC);
        check("load_c_phase", 16'(phase), 16'h40);
        start = 1'b1; mode = 2'b00; dir = 1'b1;
        step();
        start = 1'b0;
        check("rev_start_busy", 16'(busy), 16'h1);
        check("rev_start_q", 16'(q), 16'hC);
        step();
        check("rev_q", 16'(q), 16'hE);
        check("rev_done", 16'(done), 16'h1);
        check("rev_busy", 16'(busy), 16'h0);
        check("rev_phase", 16'(phase), 16'h20);
        step();
        check("rev_done_clear", 16'(done), 16'h0);

        // Mode 11 behaves as single step: reverse from 0 gives 8.
        load = 1'b1; load_val = 4'h0;
        step();
        load = 1'b0;
        start = 1'b1; mode = 2'b11; dir = 1'b1;
        step();
        start = 1'b0;
        step();
        check("m11_q", 16'(q), 16'h8);
        check("m11_done", 16'(done), 16'h1);
        check("m11_phase", 16'(phase), 16'h80);
        step();

        // Continuous forward run with hold and stop.
        load = 1'b1; load_val = 4'h0;
        step();
        load = 1'b0;
        start = 1'b1; mode = 2'b10; dir = 1'b0;
        step();
        start = 1'b0;
        step();
        check("cont_q1", 16'(q), 16'h1);
        step();
        check("cont_q3", 16'(q), 16'h3);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("hold_q%0d", i), 16'(q), 16'h3);
            check($sformatf("hold_busy%0d", i), 16'(busy), 16'h1);
        end
        hold = 1'b0;
        step();
        check("cont_q7", 16'(q), 16'h7);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop_q", 16'(q), 16'h7);
        check("stop_done", 16'(done), 16'h1);
        check("stop_busy", 16'(busy), 16'h0);
        step();
        check("stop_idle_done", 16'(done), 16'h0);
        check("stop_idle_busy", 16'(busy), 16'h0);

        // Zero-length burst.
        start = 1'b1; mode = 2'b01; dir = 1'b0; burst_len = 8'd0;
        step();
        start = 1'b0;
        check("zero_done", 16'(done), 16'h1);
        check("zero_busy", 16'(busy), 16'h0);
        check("zero_q", 16'(q), 16'h7);
        step();
        check("zero_done_clear", 16'(done), 16'h0);

        // Burst of 3 with start held high during RUN.
        start = 1'b1; mode = 2'b01; dir = 1'b0; burst_len = 8'd3;
        step();
        burst_len = 8'd9;
        step();
        check("rs_q1", 16'(q), 16'hF);
        step();
        check("rs_q2", 16'(q), 16'hE);
        check("rs_busy2", 16'(busy), 16'h1);
        step();
        start = 1'b0;
        check("rs_q3", 16'(q), 16'hC);
        check("rs_done", 16'(done), 16'h1);
        step();
        check("rs_idle_busy", 16'(busy), 16'h0);

        // start and load together: start wins.
        start = 1'b1; load = 1'b1; load_val = 4'h3; mode = 2'b00; dir = 1'b0;
        step();
        start = 1'b0; load = 1'b0;
        check("sl_q", 16'(q), 16'hC);
        check("sl_busy", 16'(busy), 16'h1);
        step();
        check("sl_step_q", 16'(q), 16'h8);
        check("sl_done", 16'(done), 16'h1);
        step();

        // Illegal load then legal load; err stays sticky.
        load = 1'b1; load_val = 4'h5;
        step();
        load = 1'b0;
        check("ill_q", 16'(q), 16'h0);
        check("ill_err", 16'(err), 16'h1);
        check("ill_phase", 16'(phase), 16'h01);
        start = 1'b1; mode = 2'b00; dir = 1'b0;
        step();
        start = 1'b0;
        step();
        check("ill_run_q", 16'(q), 16'h1);
        check("ill_run_err", 16'(err), 16'h1);
        step();
        load = 1'b1; load_val = 4'hF;
        step();
        load = 1'b0;
        check("legal_q", 16'(q), 16'hF);
        check("legal_err", 16'(err), 16'h1);
        check("legal_phase", 16'(phase), 16'h10);

        // Reset mid-run: burst of 20, reset on the 4th step edge.
        start = 1'b1; mode = 2'b01; dir = 1'b0; burst_len = 8'd20;
        step();
        start = 1'b0;
        step();
        step();
        step();
        check("pre_rst_q", 16'(q), 16'h8);
        reset = 1'b1;
        step();
        check("mid_rst_q", 16'(q), 16'h0);
        check("mid_rst_busy", 16'(busy), 16'h0);
        check("mid_rst_err", 16'(err), 16'h0);
        check("mid_rst_done", 16'(done), 16'h0);
        reset = 1'b0;
        step();
        check("post_rst_done", 16'(done), 16'h0);
        check("post_rst_q", 16'(q), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/johnson_phase_ctrl.md
Name: johnson_phase_ctrl

Overview:
Sequencer for a WIDTH-bit Johnson phase register (2*WIDTH states; for WIDTH=4 the states are 0,1,3,7,F,E,C,8). It contains the register and the FSM that decides when it advances: single-step, fixed-length burst or continuous run, in either direction, with hold, stop, preset load and illegal-state protection. It drives a decoded one-hot phase bus for downstream multi-phase timing logic.

Parameters:
WIDTH, 4, Johnson register width; sequence length is 2*WIDTH.
CNT_W, 8, width of the burst step counter.

Ports:
clk  input  1  clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
start  input  1  launch a run; accepted only in IDLE
mode  input  2  00 single step, 01 burst of burst_len steps, 10 continuous, 11 reserved (treated as 00); sampled with start
dir  input  1  0 forward (0,1,3,7..), 1 reverse (0,8,C,E..); sampled with start
burst_len  input  CNT_W  step count for mode 01; sampled with start
hold  input  1  freeze in RUN; no advance, no decrement
stop  input  1  abort the run
load  input  1  preset q from load_val; accepted only in IDLE
load_val  input  WIDTH  preset value
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when a run ends
q  output  WIDTH  Johnson register
phase  output  2*WIDTH  one-hot phase index decoded from q
err  output  1  sticky: an illegal load_val was seen

Behaviour:
- Reset (synchronous, at clk edge with reset=1): q=0, FSM=IDLE, busy=0, done=0, err=0, remaining=0, latched mode/dir=0. Reset has priority over all other inputs, including mid-run.
- States: IDLE, RUN, DONE.
- Forward advance: q <= {q[WIDTH-2:0], ~q[WIDTH-1]}. Reverse advance: q <= {~q[0], q[WIDTH-1:1]}. Wrap-around is inherent to the Johnson sequence (8 -> 0 forward, 1 -> 0 reverse).
- IDLE:
  - start=1: latch mode, dir and remaining (burst_len for mode 01, 1 for modes 00/11, don't-care for mode 10).
  - If mode=01 and burst_len=0: go to DONE directly; q does not move. Otherwise go to RUN.
  - q does not advance on the start edge; the first advance occurs on the first edge spent in RUN.
  - start and load together: start wins and load is ignored.
  - load=1 with start=0, legal load_val: q <= load_val.
  - load=1 with start=0, illegal load_val: q <= 0 and err <= 1.
- Legal value: at most one i in 0..WIDTH-2 with q[i] != q[i+1]. For WIDTH=4, 5/9/A/B/D/2/4/6 are illegal.
- RUN, evaluated each edge in this priority order:
  - stop=1: no advance; go to DONE.
  - hold=1: nothing changes.
  - Otherwise q advances in the latched direction. For modes other than continuous, remaining decrements, and if remaining==1 the FSM goes to DONE on that same edge. Continuous mode stays in RUN until stop.
  - start and load are ignored in RUN.
- Latency: single-step produces 1 advance; start edge -> RUN -> DONE, so done is asserted 2 cycles after the start edge. A burst of N with no hold produces exactly N advances, with done asserted N+1 cycles after the start edge.
- DONE: done=1 for exactly one cycle, busy=0, then return to IDLE. A start during DONE is ignored.
- busy=1 exactly while FSM=RUN.
- phase decode (combinational from q): with p = popcount(q), the index is k = p if (q[0]==1 or q==0), else 2*WIDTH-p. phase = 1<<k. For WIDTH=4: 0->k0, 1->k1, 3->k2, 7->k3, F->k4, E->k5, C->k6, 8->k7. q is always legal by construction, so phase is always one-hot.
- err is cleared only by reset.

Test Plan:
- Reset, then forward burst: start mode=01 dir=0 burst_len=10 -> q steps 1,3,7,F,E,C,8,0,1,3 on consecutive cycles, busy high for 10 cycles, done pulses once, q holds 3 and phase=0x04.
- Reverse single-step from preset: load_val=C, then start mode=00 dir=1 -> q=E after one RUN cycle, done pulses 2 cycles after start, phase=0x20.
- Hold and stop: continuous forward run, hold=1 for 3 cycles mid-run -> q frozen for those 3 cycles; stop=1 with q=7 -> q remains 7, done pulses, FSM returns to IDLE.
- Boundaries: burst_len=0 -> q unchanged and done pulses the cycle after start; start asserted during RUN -> ignored, burst length unchanged; start+load together -> load ignored.
- Illegal load: load_val=5 -> q=0, err=1 and stays 1 across later runs; load_val=F afterwards -> q=F, err still 1.
- Reset mid-run: reset at the 4th step of a burst of 20 -> next cycle q=0, busy=0, err=0, no done pulse.
